// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : run / single-step / PC-breakpoint clock-enable controller for the soft CPU
// Revision : 1.0
// ============================================================================
module cpu_run_ctrl #(
    parameter int DIV        = 100,
    parameter int DEB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic        halted,
    output logic [31:0] ce_count
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_BRK  = 2'b11
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [1:0]       run_sync;
    logic [1:0]       step_sync;
    logic             run_s;
    logic             step_s;
    logic             deb_level;
    logic             deb_prev;
    logic [DEB_W-1:0] deb_cnt;
    logic             step_req;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             bp_hit;
    logic             ce_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sync  <= 2'b00;
            step_sync <= 2'b00;
        end else begin
            run_sync  <= {run_sync[0], run_sw};
            step_sync <= {step_sync[0], step_btn};
        end
    end

    assign run_s  = run_sync[1];
    assign step_s = step_sync[1];

    // The accepted level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            deb_prev <= deb_level;
            if (step_s != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= step_s;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign step_req = deb_level & ~deb_prev;

    // Held at zero outside RUN so every entry to RUN starts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if ((cur_state != S_RUN) || (div_cnt == DIV_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick   = (cur_state == S_RUN) && (div_cnt == DIV_LAST);
    assign bp_hit = bp_en && (pc == bp_addr);

    always_comb begin
        nxt_state = cur_state;
        ce_next   = 1'b0;
        case (cur_state)
            S_HALT: begin
                if (run_s) begin
                    nxt_state = S_RUN;
                end else if (step_req) begin
                    nxt_state = S_STEP;
                end
            end
            S_RUN: begin
                if (!run_s) begin
                    nxt_state = S_HALT;
                end else if (tick) begin
                    if (bp_hit) begin
                        nxt_state = S_BRK;
                    end else begin
                        ce_next = 1'b1;
                    end
                end
            end
            S_STEP: begin
                ce_next   = 1'b1;
                nxt_state = S_HALT;
            end
            S_BRK: begin
                if (!run_s) begin
                    nxt_state = S_HALT;
                end else if (step_req) begin
                    nxt_state = S_STEP;
                end
            end
            default: begin
                nxt_state = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_HALT;
            cpu_ce    <= 1'b0;
            ce_count  <= 32'd0;
        end else begin
            cur_state <= nxt_state;
            cpu_ce    <= ce_next;
            ce_count  <= ce_count + {31'd0, ce_next};
        end
    end

    assign state  = cur_state;
    assign halted = (cur_state == S_HALT) || (cur_state == S_BRK);

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Purpose  : directed, table-driven bench for cpu_run_ctrl (DIV=4, DEB_CYCLES=16)
// Revision : 1.0
// ============================================================================
module tb_cpu_run_ctrl;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        run_sw   = 1'b0;
    logic        step_btn = 1'b0;
    logic        bp_en    = 1'b0;
    logic [31:0] bp_addr  = 32'd0;
    logic [31:0] pc       = 32'd0;
    logic        cpu_ce;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] ce_count;

    int          checks    = 0;
    int          failures  = 0;
    int          pulses    = 0;
    bit          track_pc  = 1'b0;
    logic [31:0] exp_count = 32'd0;

    typedef struct {
        logic        bp_en;
        logic [31:0] bp_addr;
        logic [31:0] pc;
        int          n;
        int          exp_pulses;
        logic [1:0]  exp_state;
        logic        exp_halted;
    } vec_t;

    vec_t vecs [0:5];

    cpu_run_ctrl #(
        .DIV        (4),
        .DEB_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .cpu_ce   (cpu_ce),
        .state    (state),
        .halted   (halted),
        .ce_count (ce_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: sample 1ns after the edge; the pc model advances on each observed pulse.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (cpu_ce === 1'b1) begin
            pulses++;
            if (track_pc) pc = pc + 32'd4;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        // Pulses land on edges 7, 11, 15 ... after run_sw rises (2 sync + 1 decide + DIV).
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0000_0010, 20, 4,  2'b01, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0010, 32'h0000_0010, 20, 0,  2'b11, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_0010, 32'h0000_0014, 20, 4,  2'b01, 1'b0};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 8,  0,  2'b11, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 43, 10, 2'b01, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 12, 2,  2'b01, 1'b0};

        // Reset state, then idle with run_sw low
        cycles(3);
        rst = 1'b0;
        check("reset cpu_ce", 32'(cpu_ce), 32'd0);
        check("reset state", 32'(state), 32'd0);
        check("reset halted", 32'(halted), 32'd1);
        check("reset ce_count", ce_count, 32'd0);
        pulses = 0;
        cycles(200);
        check("idle pulses", 32'(pulses), 32'd0);
        check("idle state", 32'(state), 32'd0);
        check("idle halted", 32'(halted), 32'd1);
        check("idle ce_count", ce_count, 32'd0);

        // Free-run vectors; run lengths are chosen so the fall of run_sw meets no tick
        // or exactly a dropped tick.
        for (int k = 0; k < 6; k++) begin
            bp_en   = vecs[k].bp_en;
            bp_addr = vecs[k].bp_addr;
            pc      = vecs[k].pc;
            pulses  = 0;
            run_sw  = 1'b1;
            cycles(vecs[k].n);
            check($sformatf("v%0d pulses", k), 32'(pulses), 32'(vecs[k].exp_pulses));
            check($sformatf("v%0d state", k), 32'(state), 32'(vecs[k].exp_state));
            check($sformatf("v%0d halted", k), 32'(halted), 32'(vecs[k].exp_halted));
            exp_count = exp_count + 32'(vecs[k].exp_pulses);
            check($sformatf("v%0d ce_count", k), ce_count, exp_count);
            run_sw = 1'b0;
            pulses = 0;
            cycles(6);
            check($sformatf("v%0d drain pulses", k), 32'(pulses), 32'd0);
            check($sformatf("v%0d drain state", k), 32'(state), 32'd0);
        end
        bp_en = 1'b0;

        // Bouncy button, then a long hold: exactly one step
        pulses = 0;
        for (int b = 0; b < 5; b++) begin
            step_btn = 1'b1;
            cycles(3);
            step_btn = 1'b0;
            cycles(3);
        end
        check("bounce pulses", 32'(pulses), 32'd0);
        step_btn = 1'b1;
        cycles(50);
        check("held pulses", 32'(pulses), 32'd1);
        check("held state", 32'(state), 32'd0);
        exp_count = exp_count + 32'd1;
        check("held ce_count", ce_count, exp_count);
        step_btn = 1'b0;
        pulses   = 0;
        cycles(30);
        check("release pulses", 32'(pulses), 32'd0);

        // Debounce threshold: 15 stable cycles rejected, 16 accepted
        for (int h = 15; h <= 16; h++) begin
            pulses   = 0;
            step_btn = 1'b1;
            cycles(h);
            step_btn = 1'b0;
            cycles(40);
            check($sformatf("hold%0d pulses", h), 32'(pulses), (h == 16) ? 32'd1 : 32'd0);
        end
        exp_count = exp_count + 32'd1;
        check("threshold ce_count", ce_count, exp_count);

        // Breakpoint at 0x10 with pc advancing by 4 per pulse
        pc       = 32'd0;
        bp_en    = 1'b1;
        bp_addr  = 32'h0000_0010;
        track_pc = 1'b1;
        pulses   = 0;
        run_sw   = 1'b1;
        cycles(40);
        check("bp pulses", 32'(pulses), 32'd4);
        check("bp state", 32'(state), 32'd3);
        check("bp halted", 32'(halted), 32'd1);
        check("bp pc", pc, 32'h0000_0010);
        exp_count = exp_count + 32'd4;
        check("bp ce_count", ce_count, exp_count);

        // Step out of BRK: STEP after 19 edges, pulse on edge 20, RUN again on edge 21
        pulses   = 0;
        step_btn = 1'b1;
        cycles(19);
        check("brk step no early pulse", 32'(pulses), 32'd0);
        check("brk step state", 32'(state), 32'd2);
        cyc();
        check("brk step cpu_ce", 32'(cpu_ce), 32'd1);
        check("brk step then halt", 32'(state), 32'd0);
        check("brk step pc", pc, 32'h0000_0014);
        cyc();
        check("brk step single", 32'(cpu_ce), 32'd0);
        check("brk resume state", 32'(state), 32'd1);
        cycles(8);
        check("resume pulses", 32'(pulses), 32'd3);
        check("resume pc", pc, 32'h0000_001C);
        exp_count = exp_count + 32'd3;
        check("resume ce_count", ce_count, exp_count);
        run_sw   = 1'b0;
        step_btn = 1'b0;
        pulses   = 0;
        cycles(40);
        check("stop pulses", 32'(pulses), 32'd0);
        check("stop state", 32'(state), 32'd0);
        check("stop halted", 32'(halted), 32'd1);
        track_pc = 1'b0;
        bp_en    = 1'b0;

        // Reset asserted during the STEP cycle cuts the pending pulse
        pulses   = 0;
        step_btn = 1'b1;
        cycles(19);
        check("pre-rst state", 32'(state), 32'd2);
        rst = 1'b1;
        #1;
        check("rst cpu_ce", 32'(cpu_ce), 32'd0);
        check("rst state", 32'(state), 32'd0);
        check("rst halted", 32'(halted), 32'd1);
        check("rst ce_count", ce_count, 32'd0);
        step_btn = 1'b0;
        cycles(3);
        rst    = 1'b0;
        pulses = 0;
        cycles(40);
        check("post-rst pulses", 32'(pulses), 32'd0);
        check("post-rst ce_count", ce_count, 32'd0);
        check("post-rst state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
